// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one AXI-Lite UART TX data register among N_REQ byte producers.
// Requesters are served round-robin. Each accepted byte becomes one AXI-Lite
// single-beat write of {24'h0, byte} to BASE_ADDR + TX_OFFSET with strobe 0001.
// A requester that sends a byte other than '\n' takes a line lock and keeps the
// grant until its '\n' write completes, so console lines never interleave.
// If the lock owner stays silent for LOCK_TIMEOUT idle cycles, the lock is
// dropped and round-robin resumes.
//
// Optional feature (macro UART_ARB_CR_INSERT_EN): an accepted '\n' is sent as
// two complete writes, 0x0D then 0x0A. The lock is released after the second B.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid[N_REQ]    requester i has a byte
//   req_data[8*N_REQ]   byte of requester i at [8i+7:8i]
//   req_ready[N_REQ]    one-hot acceptance pulse (same cycle as the grant)
//   axi_aw_* / axi_w_*  AXI-Lite write address / write data (master side)
//   axi_b_*             AXI-Lite write response
//   axi_ar_* / axi_r_*  AXI-Lite read channels, unused (ar_valid=0, r_ready=1)
//   lock_valid          a line lock is held
//   lock_owner[4]       index of the lock holder, 0 when no lock
//   busy                write transaction in progress (FSM not IDLE)
//   err                 sticky: a non-OKAY write response was seen
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int          N_REQ        = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [31:0] TX_OFFSET    = 32'h04,
    parameter int          LOCK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 axi_aw_valid,
    input  logic                 axi_aw_ready,
    output logic [31:0]          axi_aw_addr,
    output logic [2:0]           axi_aw_prot,
    output logic                 axi_w_valid,
    input  logic                 axi_w_ready,
    output logic [31:0]          axi_w_data,
    output logic [3:0]           axi_w_strb,
    input  logic                 axi_b_valid,
    output logic                 axi_b_ready,
    input  logic [1:0]           axi_b_resp,
    output logic                 axi_ar_valid,
    output logic [31:0]          axi_ar_addr,
    output logic [2:0]           axi_ar_prot,
    input  logic                 axi_ar_ready,
    input  logic                 axi_r_valid,
    input  logic [31:0]          axi_r_data,
    input  logic [1:0]           axi_r_resp,
    output logic                 axi_r_ready,
    output logic                 lock_valid,
    output logic [3:0]           lock_owner,
    output logic                 busy,
    output logic                 err
);

    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_B} state_e;

    state_e           state_q, state_d;
    logic [3:0]       rr_ptr_q, rr_ptr_d;
    logic             lock_valid_q, lock_valid_d;
    logic [3:0]       lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             aw_valid_q, aw_valid_d;
    logic             w_valid_q, w_valid_d;
    logic             b_ready_q, b_ready_d;
    logic             err_q, err_d;
`ifdef UART_ARB_CR_INSERT_EN
    logic             cr_phase_q, cr_phase_d;
`endif

    logic             hit_hi, hit_lo, owner_valid, gnt_any, grant;
    logic [3:0]       idx_hi, idx_lo, gnt_idx;
    logic [7:0]       gnt_byte, tx_byte;
    logic             last_beat;

    // Grant selection. Scanning downward leaves the lowest matching index in
    // idx_hi (at or above rr_ptr) and idx_lo (anywhere, used after wrap).
    always_comb begin
        hit_hi      = 1'b0;
        hit_lo      = 1'b0;
        idx_hi      = '0;
        idx_lo      = '0;
        owner_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                hit_lo = 1'b1;
                idx_lo = 4'(i);
                if (4'(i) >= rr_ptr_q) begin
                    hit_hi = 1'b1;
                    idx_hi = 4'(i);
                end
            end
            if (4'(i) == lock_owner_q) owner_valid = req_valid[i];
        end
        if (lock_valid_q) begin
            gnt_any = owner_valid;
            gnt_idx = lock_owner_q;
        end else begin
            gnt_any = hit_lo;
            gnt_idx = hit_hi ? idx_hi : idx_lo;
        end
        // req_ready is a same-cycle handshake, so it is combinational; it is
        // gated by rst_n so no acceptance can be signalled while in reset.
        grant     = rst_n && (state_q == S_IDLE) && gnt_any;
        gnt_byte  = '0;
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (4'(i) == gnt_idx) begin
                gnt_byte     = req_data[8*i +: 8];
                req_ready[i] = grant;
            end
        end
    end

`ifdef UART_ARB_CR_INSERT_EN
    assign tx_byte   = cr_phase_q ? CR : byte_q;
    assign last_beat = !cr_phase_q;
`else
    assign tx_byte   = byte_q;
    assign last_beat = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        to_cnt_d     = to_cnt_q;
        byte_d       = byte_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        b_ready_d    = b_ready_q;
        err_d        = err_q;
`ifdef UART_ARB_CR_INSERT_EN
        cr_phase_d   = cr_phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    byte_d     = gnt_byte;
                    rr_ptr_d   = (gnt_idx == 4'(N_REQ - 1)) ? 4'd0 : gnt_idx + 4'd1;
                    to_cnt_d   = '0;
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    state_d    = S_ISSUE;
                    // A '\n' leaves the lock as is; it is released when its write completes.
                    if (gnt_byte != LF) begin
                        lock_valid_d = 1'b1;
                        lock_owner_d = gnt_idx;
                    end
`ifdef UART_ARB_CR_INSERT_EN
                    cr_phase_d = (gnt_byte == LF);
`endif
                end else if (lock_valid_q && !owner_valid) begin
                    if (to_cnt_q == TO_LAST) begin
                        to_cnt_d     = '0;
                        lock_valid_d = 1'b0;
                        lock_owner_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                // AW and W complete independently; move on once both are done.
                aw_valid_d = aw_valid_q && !axi_aw_ready;
                w_valid_d  = w_valid_q && !axi_w_ready;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = S_WAIT_B;
                    b_ready_d = 1'b1;
                end
            end
            S_WAIT_B: begin
                if (axi_b_valid && b_ready_q) begin
                    b_ready_d = 1'b0;
                    if (axi_b_resp != 2'b00) err_d = 1'b1;
                    if (last_beat) begin
                        state_d = S_IDLE;
                        if (byte_q == LF) begin
                            lock_valid_d = 1'b0;
                            lock_owner_d = '0;
                        end
                    end else begin
                        // Inserted CR done; now send the LF itself.
                        state_d    = S_ISSUE;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end
`ifdef UART_ARB_CR_INSERT_EN
                    cr_phase_d = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            to_cnt_q     <= '0;
            byte_q       <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            err_q        <= 1'b0;
`ifdef UART_ARB_CR_INSERT_EN
            cr_phase_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            to_cnt_q     <= to_cnt_d;
            byte_q       <= byte_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            b_ready_q    <= b_ready_d;
            err_q        <= err_d;
`ifdef UART_ARB_CR_INSERT_EN
            cr_phase_q   <= cr_phase_d;
`endif
        end
    end

    assign axi_aw_valid = aw_valid_q;
    assign axi_aw_addr  = BASE_ADDR + TX_OFFSET;
    assign axi_aw_prot  = 3'b000;
    assign axi_w_valid  = w_valid_q;
    assign axi_w_data   = {24'h0, tx_byte};
    assign axi_w_strb   = 4'b0001;
    assign axi_b_ready  = b_ready_q;
    assign axi_ar_valid = 1'b0;
    assign axi_ar_addr  = '0;
    assign axi_ar_prot  = 3'b000;
    assign axi_r_ready  = 1'b1;
    assign lock_valid   = lock_valid_q;
    assign lock_owner   = lock_owner_q;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;

    // Read channel is never used; these inputs are intentionally ignored.
    logic unused_rd;
    assign unused_rd = ^{axi_ar_ready, axi_r_valid, axi_r_data, axi_r_resp};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with a small AXI-Lite write slave model.
// A table of single-byte transfers is applied in a loop; hand-written
// sequences cover line locking, round-robin order, lock timeout, error
// stickiness, a stalled AW channel and reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int          N   = 4;
    localparam logic [31:0] BA  = 32'h1000_0000;
    localparam logic [31:0] OFF = 32'h0000_0004;
    localparam int          LT  = 10;
`ifdef UART_ARB_CR_INSERT_EN
    localparam bit CR_EN = 1'b1;
`else
    localparam bit CR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        axi_aw_valid, axi_w_valid, axi_b_ready, axi_ar_valid, axi_r_ready;
    logic        axi_aw_ready, axi_w_ready, axi_b_valid;
    logic [31:0] axi_aw_addr, axi_w_data, axi_ar_addr;
    logic [2:0]  axi_aw_prot, axi_ar_prot;
    logic [3:0]  axi_w_strb;
    logic [1:0]  axi_b_resp;
    logic        lock_valid, busy, err;
    logic [3:0]  lock_owner;
    logic        aw_ready_cfg;
    logic [1:0]  resp_cfg;

    always #5 clk = ~clk;

    assign axi_aw_ready = aw_ready_cfg;
    assign axi_w_ready  = 1'b1;

    uart_tx_arbiter #(
        .N_REQ(N), .BASE_ADDR(BA), .TX_OFFSET(OFF), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
        .axi_aw_addr(axi_aw_addr), .axi_aw_prot(axi_aw_prot),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
        .axi_ar_valid(axi_ar_valid), .axi_ar_addr(axi_ar_addr), .axi_ar_prot(axi_ar_prot),
        .axi_ar_ready(1'b0), .axi_r_valid(1'b0), .axi_r_data(32'h0), .axi_r_resp(2'b00),
        .axi_r_ready(axi_r_ready),
        .lock_valid(lock_valid), .lock_owner(lock_owner), .busy(busy), .err(err)
    );

    // AXI-Lite write slave: B is returned the cycle after both AW and W are taken.
    wire aw_hs = axi_aw_valid & axi_aw_ready;
    wire w_hs  = axi_w_valid & axi_w_ready;
    wire b_hs  = axi_b_valid & axi_b_ready;
    logic        aw_got, w_got;
    int          wr_cnt = 0, aw_cnt = 0, b_cnt = 0;
    logic [31:0] wlog [0:255];
    logic [31:0] last_awaddr;
    logic [2:0]  last_awprot;
    logic [3:0]  last_wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            axi_b_valid <= 1'b0;
            axi_b_resp  <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_cnt      <= aw_cnt + 1;
                last_awaddr <= axi_aw_addr;
                last_awprot <= axi_aw_prot;
            end
            if (w_hs) begin
                wlog[wr_cnt[7:0]] <= axi_w_data;
                last_wstrb        <= axi_w_strb;
                wr_cnt            <= wr_cnt + 1;
            end
            if (b_hs) begin
                axi_b_valid <= 1'b0;
                b_cnt       <= b_cnt + 1;
            end
            if ((aw_got | aw_hs) && (w_got | w_hs)) begin
                axi_b_valid <= 1'b1;
                axi_b_resp  <= resp_cfg;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
            end else begin
                aw_got <= aw_got | aw_hs;
                w_got  <= w_got | w_hs;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] oh);
        idx_of = 15;
        for (int i = 0; i < 4; i++) if (oh == (4'b0001 << i)) idx_of = i;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        aw_ready_cfg = 1'b1;
        resp_cfg     = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Waits at negedges for an acceptance; counts idle cycles spent stalled.
    task automatic wait_grant(output int idle_stall, output logic [3:0] rdy);
        idle_stall = 0;
        rdy        = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                rdy = req_ready;
                return;
            end
            if (!busy) idle_stall++;
            cyc();
        end
    endtask

    // Called at a negedge of cycle 'cycles'; returns the first cycle with busy=0.
    task automatic wait_idle(inout int cycles);
        while (busy && cycles < 300) begin
            cyc();
            @(negedge clk);
            cycles++;
        end
        chk("returned_to_idle", busy, 1'b0);
    endtask

    task automatic send(input int idx, input logic [7:0] b, output logic [3:0] rdy, output int lat);
        int st;
        cyc();
        req_valid[idx]       = 1'b1;
        req_data[8*idx +: 8] = b;
        wait_grant(st, rdy);
        cyc();
        req_valid[idx] = 1'b0;
        @(negedge clk);
        lat = 1;
        wait_idle(lat);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] b;
        logic [3:0] exp_rdy;
        logic       exp_lock;
        logic [3:0] exp_owner;
    } vec_t;

    vec_t vecs [7];

    initial begin : main
        logic [3:0] rdy, pend;
        int         lat, st, w0, b0, a0, nwr, ng, pos, nexp;
        int         order [4];
        int         exp_order [4];
        logic [7:0] line1 [3];
        logic [7:0] exp2 [5];

        vecs[0] = '{0, 8'h41, 4'b0001, 1'b1, 4'd0};
        vecs[1] = '{0, 8'h0A, 4'b0001, 1'b0, 4'd0};
        vecs[2] = '{3, 8'h7E, 4'b1000, 1'b1, 4'd3};
        vecs[3] = '{3, 8'h0A, 4'b1000, 1'b0, 4'd0};
        vecs[4] = '{1, 8'h0A, 4'b0010, 1'b0, 4'd0};
        vecs[5] = '{2, 8'h30, 4'b0100, 1'b1, 4'd2};
        vecs[6] = '{2, 8'h0A, 4'b0100, 1'b0, 4'd0};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_aw_valid", axi_aw_valid, 1'b0);
        chk("rst_w_valid", axi_w_valid, 1'b0);
        chk("rst_b_ready", axi_b_ready, 1'b0);
        chk("rst_lock", {lock_valid, lock_owner}, 5'b0);
        chk("rst_busy_err", {busy, err}, 2'b00);
        chk("rst_ar_valid", axi_ar_valid, 1'b0);
        chk("rst_r_ready", axi_r_ready, 1'b1);

        // Table of single-byte transfers
        for (int v = 0; v < 7; v++) begin
            w0  = wr_cnt;
            b0  = b_cnt;
            nwr = (CR_EN && vecs[v].b == 8'h0A) ? 2 : 1;
            send(vecs[v].idx, vecs[v].b, rdy, lat);
            chk($sformatf("v%0d_req_ready", v), rdy, vecs[v].exp_rdy);
            chk($sformatf("v%0d_latency", v), lat, 3 * nwr);
            chk($sformatf("v%0d_nwrites", v), wr_cnt - w0, nwr);
            chk($sformatf("v%0d_nb", v), b_cnt - b0, nwr);
            chk($sformatf("v%0d_wdata", v), wlog[(wr_cnt - 1) & 255], {24'h0, vecs[v].b});
            if (nwr == 2) chk($sformatf("v%0d_cr_first", v), wlog[(wr_cnt - 2) & 255], 32'h0000_000D);
            chk($sformatf("v%0d_addr", v), last_awaddr, 32'h1000_0004);
            chk($sformatf("v%0d_prot_strb", v), {last_awprot, last_wstrb}, 7'b000_0001);
            chk($sformatf("v%0d_lock_valid", v), lock_valid, vecs[v].exp_lock);
            chk($sformatf("v%0d_lock_owner", v), lock_owner, vecs[v].exp_owner);
            chk($sformatf("v%0d_err", v), err, 1'b0);
        end

        // Line lock: req1 sends "AB\n" while req2 waits
        line1[0] = 8'h41; line1[1] = 8'h42; line1[2] = 8'h0A;
        exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 1; exp_order[3] = 2;
        if (CR_EN) begin
            exp2[0] = 8'h41; exp2[1] = 8'h42; exp2[2] = 8'h0D; exp2[3] = 8'h0A; exp2[4] = 8'h5A;
            nexp = 5;
        end else begin
            exp2[0] = 8'h41; exp2[1] = 8'h42; exp2[2] = 8'h0A; exp2[3] = 8'h5A; exp2[4] = 8'h00;
            nexp = 4;
        end
        do_reset();
        w0 = wr_cnt; pos = 0; ng = 0;
        cyc();
        req_valid = 4'b0110;
        req_data  = {8'h00, 8'h5A, line1[0], 8'h00};
        for (int k = 0; k < 200 && ng < 4; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                order[ng] = idx_of(req_ready);
                ng++;
                if (req_ready[1]) pos++;
            end
            cyc();
            if (pos < 3) req_data[15:8] = line1[pos];
            else req_valid[1] = 1'b0;
            if (ng == 4) req_valid[2] = 1'b0;
        end
        @(negedge clk);
        lat = 1;
        wait_idle(lat);
        chk("t2_grants", ng, 4);
        for (int j = 0; j < 4; j++) chk($sformatf("t2_order%0d", j), order[j], exp_order[j]);
        chk("t2_nwrites", wr_cnt - w0, nexp);
        for (int j = 0; j < nexp; j++)
            chk($sformatf("t2_data%0d", j), wlog[(w0 + j) & 255], {24'h0, exp2[j]});
        chk("t2_lock_owner", {lock_valid, lock_owner}, {1'b1, 4'd2});

        // Round-robin order from rr_ptr=2 with wrap: expect 3, 0, 1
        do_reset();
        send(1, 8'h0A, rdy, lat);
        cyc();
        req_valid = 4'b1011;
        req_data  = 32'h0A00_0A0A;
        ng = 0;
        for (int k = 0; k < 200 && ng < 3; k++) begin
            @(negedge clk);
            pend = req_ready;
            if (req_ready != 4'b0000) begin
                order[ng] = idx_of(req_ready);
                ng++;
            end
            cyc();
            req_valid = req_valid & ~pend;
        end
        @(negedge clk);
        lat = 1;
        wait_idle(lat);
        chk("rr_grants", ng, 3);
        chk("rr_first", order[0], 3);
        chk("rr_wrap", order[1], 0);
        chk("rr_third", order[2], 1);

        // Lock timeout: req3 stalls exactly LT idle cycles behind req0's lock
        do_reset();
        cyc();
        req_valid = 4'b1001;
        req_data  = {8'h33, 16'h0000, 8'h48};
        wait_grant(st, rdy);
        chk("t3_first_grant", rdy, 4'b0001);
        cyc();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t3_lock_held", {lock_valid, lock_owner}, {1'b1, 4'd0});
        cyc();
        wait_grant(st, rdy);
        chk("t3_req3_grant", rdy, 4'b1000);
        chk("t3_stall_cycles", st, LT);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("t3_new_owner", {lock_valid, lock_owner}, {1'b1, 4'd3});
        lat = 1;
        wait_idle(lat);

        // Error response is sticky
        do_reset();
        resp_cfg = 2'b10;
        send(1, 8'h0A, rdy, lat);
        chk("t4_err_set", err, 1'b1);
        resp_cfg = 2'b00;
        send(1, 8'h0A, rdy, lat);
        chk("t4_err_sticky", err, 1'b1);
        send(2, 8'h0A, rdy, lat);
        chk("t4_err_sticky2", err, 1'b1);

        // AW held off for 5 cycles: W completes first, one B
        do_reset();
        a0 = aw_cnt; w0 = wr_cnt; b0 = b_cnt;
        aw_ready_cfg = 1'b0;
        cyc();
        req_valid = 4'b0001;
        req_data  = 32'h0000_0041;
        wait_grant(st, rdy);
        chk("t4b_grant", rdy, 4'b0001);
        cyc();
        req_valid = '0;
        @(negedge clk);
        chk("t4b_c1_valids", {axi_aw_valid, axi_w_valid}, 2'b11);
        cyc();
        @(negedge clk);
        chk("t4b_c2_valids", {axi_aw_valid, axi_w_valid}, 2'b10);
        cyc(); cyc(); cyc();
        @(negedge clk);
        chk("t4b_c5_valids", {axi_aw_valid, axi_w_valid, axi_b_ready}, 3'b100);
        cyc();
        aw_ready_cfg = 1'b1;
        @(negedge clk);
        lat = 6;
        wait_idle(lat);
        chk("t4b_latency", lat, 8);
        chk("t4b_naw", aw_cnt - a0, 1);
        chk("t4b_nw", wr_cnt - w0, 1);
        chk("t4b_nb", b_cnt - b0, 1);
        chk("t4b_data", wlog[(wr_cnt - 1) & 255], 32'h0000_0041);

        // Reset while waiting for B
        do_reset();
        b0 = b_cnt;
        cyc();
        req_valid = 4'b0100;
        req_data  = 32'h0055_0000;
        wait_grant(st, rdy);
        chk("t5_grant", rdy, 4'b0100);
        cyc();
        cyc();
        chk("t5_in_wait_b", {busy, axi_b_ready}, 2'b11);
        chk("t5_lock_before", {lock_valid, lock_owner}, {1'b1, 4'd2});
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5_rst_outputs%0d", k),
                {req_ready, axi_aw_valid, axi_w_valid, axi_b_ready, lock_valid, lock_owner, busy, err},
                15'b0);
            cyc();
        end
        req_valid = '0;
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        chk("t5_no_b_taken", b_cnt - b0, 0);
        chk("t5_idle_after", {busy, lock_valid, req_ready}, 6'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "time limit");
    end

endmodule
